// File: rtl/axi4_s2mm_burst_sequencer_pkg.sv
// Shared definitions for the stream-to-memory control path: sequencer state
// encoding and burst sizing helpers also used by the writer-side blocks.
package axi4_s2mm_burst_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_ACCEPT    = 3'd2,
      ST_WAIT_IDLE = 3'd3,
      ST_ABORT     = 3'd4
   } state_t;

   // Ceiling log2; clogb2(1) = 0.
   function automatic int clogb2(input longint unsigned value);
      int result;
      result = 0;
      while ((64'd1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic int burst_bytes(input int burst_len, input int data_width);
      return burst_len * data_width / 8;
   endfunction

endpackage

// File: rtl/axi4_s2mm_burst_sequencer.sv
// Splits one software command into consecutive single-burst jobs for the
// stream-to-memory writer and owns the writer's abort handshake.
module axi4_s2mm_burst_sequencer
   import axi4_s2mm_burst_sequencer_pkg::*;
#(
   parameter int C_AXI_DATA_WIDTH   = 32,
   parameter int C_M_AXI_BURST_LEN  = 256,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_COUNT_WIDTH      = 16
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_address,
   input  logic [C_COUNT_WIDTH-1:0]      cmd_burst_count,
   input  logic                          cmd_start,
   input  logic                          cmd_abort,
   output logic                          busy,
   output logic                          done,
   output logic                          aborted,
   output logic                          cmd_error,
   output logic [C_COUNT_WIDTH-1:0]      bursts_completed,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] write_address,
   output logic                          write_start,
   input  logic                          output_idle,
   output logic                          sw_reset,
   input  logic                          sw_reset_ok
);

   localparam int BURST_BYTES = burst_bytes(C_M_AXI_BURST_LEN, C_AXI_DATA_WIDTH);
   localparam int OFFSET_BITS = clogb2(longint'(BURST_BYTES));
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] OFFSET_MASK =
      C_M_AXI_ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STEP = C_M_AXI_ADDR_WIDTH'(BURST_BYTES);

   state_t                          state_reg;
   state_t                          state_next;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_reg;
   logic [C_COUNT_WIDTH-1:0]        count_reg;
   logic [C_COUNT_WIDTH-1:0]        bursts_reg;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   write_address_reg;
   logic                            write_start_reg;
   logic                            done_reg;
   logic                            aborted_reg;
   logic                            cmd_error_reg;

   logic                            start_misaligned;
   logic                            start_empty;
   logic                            burst_last;

   assign start_misaligned = |(cmd_address & OFFSET_MASK);
   assign start_empty      = (cmd_burst_count == '0);
   assign burst_last       = (C_COUNT_WIDTH'(bursts_reg + 1'b1) == count_reg);

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (cmd_start && !start_misaligned && !start_empty) begin
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_abort) begin
               state_next = ST_ABORT;
            end else if (output_idle) begin
               state_next = ST_ACCEPT;
            end
         end
         // The write_start cycle is skipped: the writer still reports idle there.
         ST_ACCEPT: begin
            if (cmd_abort) begin
               state_next = ST_ABORT;
            end else if (!write_start_reg && !output_idle) begin
               state_next = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (cmd_abort) begin
               state_next = ST_ABORT;
            end else if (output_idle) begin
               state_next = burst_last ? ST_IDLE : ST_ISSUE;
            end
         end
         ST_ABORT: begin
            if (sw_reset_ok) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy             = (state_reg != ST_IDLE);
      sw_reset         = (state_reg == ST_ABORT);
      done             = done_reg;
      aborted          = aborted_reg;
      cmd_error        = cmd_error_reg;
      bursts_completed = bursts_reg;
      write_address    = write_address_reg;
      write_start      = write_start_reg;
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         addr_reg          <= '0;
         count_reg         <= '0;
         bursts_reg        <= '0;
         write_address_reg <= '0;
         write_start_reg   <= 1'b0;
         done_reg          <= 1'b0;
         aborted_reg       <= 1'b0;
         cmd_error_reg     <= 1'b0;
      end else begin
         write_start_reg <= 1'b0;
         done_reg        <= 1'b0;
         aborted_reg     <= 1'b0;
         cmd_error_reg   <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (cmd_start) begin
                  if (start_misaligned) begin
                     cmd_error_reg <= 1'b1;
                  end else if (start_empty) begin
                     done_reg <= 1'b1;
                  end else begin
                     addr_reg   <= cmd_address;
                     count_reg  <= cmd_burst_count;
                     bursts_reg <= '0;
                  end
               end
            end
            ST_ISSUE: begin
               if (!cmd_abort && output_idle) begin
                  write_start_reg   <= 1'b1;
                  write_address_reg <= addr_reg;
               end
            end
            // An abort in the completion cycle wins; that burst is not counted.
            ST_WAIT_IDLE: begin
               if (!cmd_abort && output_idle) begin
                  bursts_reg <= C_COUNT_WIDTH'(bursts_reg + 1'b1);
                  addr_reg   <= addr_reg + ADDR_STEP;
                  done_reg   <= burst_last;
               end
            end
            ST_ABORT: begin
               aborted_reg <= sw_reset_ok;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/axi4_s2mm_burst_sequencer.md
Name: axi4_s2mm_burst_sequencer

Overview:
Control stage directly upstream of the stream-to-memory writer. It takes one software command (base address, burst count) and splits it into consecutive single-burst jobs. For each job it drives the writer's write_address/write_start and waits for its output_idle. It also owns the writer's sw_reset/sw_reset_ok abort handshake and exposes busy/done/error status to the register bank.

Parameters:
C_AXI_DATA_WIDTH, 32, stream/MM data width in bits; must match the writer.
C_M_AXI_BURST_LEN, 256, beats per burst; must match the writer. BURST_BYTES = C_M_AXI_BURST_LEN*C_AXI_DATA_WIDTH/8.
C_M_AXI_ADDR_WIDTH, 32, address width.
C_COUNT_WIDTH, 16, width of the burst-count and progress counters.

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
cmd_address  in  ADDR_WIDTH  base byte address of transfer
cmd_burst_count  in  COUNT_WIDTH  number of bursts to write
cmd_start  in  1  one-cycle start request
cmd_abort  in  1  one-cycle abort request
busy  out  1  high from accepted start until done/abort completes
done  out  1  one-cycle pulse: all bursts finished
aborted  out  1  one-cycle pulse: abort completed
cmd_error  out  1  one-cycle pulse: start rejected (misaligned address)
bursts_completed  out  COUNT_WIDTH  bursts finished in current/last command
write_address  out  ADDR_WIDTH  to writer
write_start  out  1  to writer, one-cycle pulse
output_idle  in  1  from writer
sw_reset  out  1  to writer
sw_reset_ok  in  1  from writer

Behaviour:
- Reset (ARESETN=0 at posedge): state IDLE. All outputs 0, including busy, done, aborted, cmd_error, bursts_completed, write_address, write_start and sw_reset.
- IDLE: cmd_start is sampled.
  - If cmd_address[log2(BURST_BYTES)-1:0] != 0: cmd_error pulses next cycle; stay IDLE.
  - Else if cmd_burst_count == 0: done pulses next cycle with busy kept 0; no write_start issued.
  - Else: latch address and count, clear bursts_completed, set busy, go to ISSUE.
- ISSUE: entered only when output_idle=1; if output_idle=0, wait here. Drive write_address = current address and write_start=1 for exactly one cycle; go to ACCEPT.
- ACCEPT: wait for output_idle=0. The writer drops idle one cycle after sampling write_start. The cycle in which write_start is high is never used to evaluate output_idle. Then go to WAIT_IDLE.
- WAIT_IDLE: on output_idle=1, increment bursts_completed and add BURST_BYTES to the address.
  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
  - If bursts_completed+1 == latched count: go to IDLE, drop busy, pulse done in the same cycle.
  - Else go to ISSUE.
- write_address holds its last value outside ISSUE.
- cmd_start while busy: ignored, no error.
- cmd_abort in any busy state (ISSUE/ACCEPT/WAIT_IDLE): go to ABORT, assert sw_reset next cycle, and hold it until sw_reset_ok=1 is sampled. Next cycle: sw_reset=0, busy=0, aborted pulse, go IDLE. bursts_completed keeps its value.
- cmd_abort in IDLE: ignored.
- Abort has priority over a simultaneous WAIT_IDLE completion. The completion is then not counted.
- cmd_start and cmd_abort in the same IDLE cycle: start processed, abort ignored.
- ARESETN low mid-transfer: immediate return to IDLE with reset values; no done/aborted pulse.
- Latency: cmd_start to first write_start = 2 cycles when output_idle=1.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ISSUE, ACCEPT, WAIT_IDLE, ABORT);
  - a BURST_BYTES constant function;
  - a clogb2 function, reused by the writer-side blocks.
- No sub-module; the single FSM plus address/count registers stay in one module.

Test Plan:
Bench parameters for all scenarios: DATA 32, BURST_LEN 16 (BURST_BYTES 64). A writer model holds output_idle low for 20 cycles after each write_start.
- cmd_address=0x1000, count=3 -> write_start pulses with write_address 0x1000, 0x1040, 0x1080; one done pulse; bursts_completed=3; busy low after.
- cmd_address=0x1010 -> cmd_error pulse next cycle; no write_start; busy stays 0.
- count=0 -> done pulse one cycle after cmd_start; no write_start; busy never high.
- count=4, cmd_abort during the 2nd burst -> sw_reset high until model returns sw_reset_ok (10 cycles later) -> aborted pulse; bursts_completed=1; no done.
- cmd_address=0xFFFFFFC0, count=2 -> write_address 0xFFFFFFC0 then 0x00000000; done.
- Second cmd_start during busy -> ignored; ARESETN low mid-burst -> all outputs 0 next cycle, and a new command then runs normally.
